vector_fp_mul_pipe: RTL and testbench

Pipelined, parametrised successor to the vector FP multiplier. It runs LANES independent IEEE-style floating-point multiplies per issued vector and supports a per-lane enable mask. It has a fixed 3-cycle latency, full valid/ready backpressure and per-lane status flags. It sits in the Execute stage VECTOR_ALU and is selected for vector FP multiply ops.

---
 rtl/vfp_pkg.sv | 27 ++
 rtl/vfp_mul_lane.sv | 151 +++++++++++++++
 rtl/vector_fp_mul_pipe.sv | 68 ++++++
 tb/tb_vector_fp_mul_pipe.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfp_pkg.sv
// Shared types and defaults for the vector floating-point multiplier.
// Lane classification, status flag bundle and exponent bias helper.
package vfp_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int WIDTH_DEF = 1 + EXP_W_DEF + MAN_W_DEF;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } lane_cls_e;

  typedef struct packed {
    logic v;
    logic u;
    logic n;
    logic z;
  } vfp_flags_t;

  function automatic int vfp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/vfp_mul_lane.sv
// One lane of the vector FP multiplier: a 3-stage datapath that only moves
// when the shared advance enable is high, so a stall freezes every stage.
module vfp_mul_lane
  import vfp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv_i,
  input  logic                 en_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic [EXP_W+MAN_W:0] res_o,
  output vfp_flags_t           flags_o
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0]    BIAS_X   = XW'(vfp_bias(EXP_W));
  localparam logic [MAN_W-1:0] QNAN_MAN = {1'b1, {(MAN_W - 1){1'b0}}};

  // Denormals (exp == 0) are flushed and treated as zero.
  function automatic lane_cls_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (e == '1) return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

  // ---------------- S1: unpack, classify, product, exponent sum
  lane_cls_e       cls_a1_d, cls_b1_d, cls_a1_q, cls_b1_q;
  logic [PW-1:0]   prod1_d, prod1_q;
  logic [XW-1:0]   esum1_d, esum1_q;
  logic            en1_q, sign1_q;

  assign cls_a1_d = classify(a_i[W-2:MAN_W], a_i[MAN_W-1:0]);
  assign cls_b1_d = classify(b_i[W-2:MAN_W], b_i[MAN_W-1:0]);
  assign prod1_d  = PW'({1'b1, a_i[MAN_W-1:0]}) * PW'({1'b1, b_i[MAN_W-1:0]});
  // Two's complement in XW bits covers the whole e1+e2-bias(+1) range.
  assign esum1_d  = XW'(a_i[W-2:MAN_W]) + XW'(b_i[W-2:MAN_W]) - BIAS_X;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en1_q    <= 1'b0;
      sign1_q  <= 1'b0;
      cls_a1_q <= ZERO;
      cls_b1_q <= ZERO;
      prod1_q  <= '0;
      esum1_q  <= '0;
    end else if (adv_i) begin
      en1_q    <= en_i;
      sign1_q  <= a_i[W-1] ^ b_i[W-1];
      cls_a1_q <= cls_a1_d;
      cls_b1_q <= cls_b1_d;
      prod1_q  <= prod1_d;
      esum1_q  <= esum1_d;
    end
  end

  // ---------------- S2: normalise, overflow/underflow detect
  logic             shift;
  logic [XW-1:0]    enorm;
  logic [MAN_W-1:0] man2_d, man2_q;
  logic [EXP_W-1:0] exp2_q;
  logic             ovf2_d, unf2_d, ovf2_q, unf2_q;
  logic             en2_q, sign2_q;
  lane_cls_e        cls_a2_q, cls_b2_q;

  assign shift  = prod1_q[PW-1];
  assign man2_d = shift ? prod1_q[PW-2:MAN_W+1] : prod1_q[PW-3:MAN_W];
  assign enorm  = esum1_q + XW'(shift);
  assign ovf2_d = !enorm[XW-1] && (enorm[XW-2:0] >= {1'b0, {EXP_W{1'b1}}});
  assign unf2_d = enorm[XW-1] || (enorm == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en2_q    <= 1'b0;
      sign2_q  <= 1'b0;
      cls_a2_q <= ZERO;
      cls_b2_q <= ZERO;
      man2_q   <= '0;
      exp2_q   <= '0;
      ovf2_q   <= 1'b0;
      unf2_q   <= 1'b0;
    end else if (adv_i) begin
      en2_q    <= en1_q;
      sign2_q  <= sign1_q;
      cls_a2_q <= cls_a1_q;
      cls_b2_q <= cls_b1_q;
      man2_q   <= man2_d;
      exp2_q   <= enorm[EXP_W-1:0];
      ovf2_q   <= ovf2_d;
      unf2_q   <= unf2_d;
    end
  end

  // ---------------- S3: special-case select, pack, flags
  logic [W-1:0] res_d, res_q;
  vfp_flags_t   flags_d, flags_q;
  logic         any_nan, any_inf, any_zero;

  assign any_nan  = (cls_a2_q == NAN)  || (cls_b2_q == NAN);
  assign any_inf  = (cls_a2_q == INF)  || (cls_b2_q == INF);
  assign any_zero = (cls_a2_q == ZERO) || (cls_b2_q == ZERO);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    if (!en2_q) begin
      res_d = '0;
    end else if (any_nan || (any_inf && any_zero)) begin
      res_d     = {1'b0, {EXP_W{1'b1}}, QNAN_MAN};
      flags_d.v = 1'b1;
    end else if (any_inf) begin
      res_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      res_d = {sign2_q, {(W - 1){1'b0}}};
    end else if (ovf2_q) begin
      res_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d.v = 1'b1;
    end else if (unf2_q) begin
      res_d     = {sign2_q, {(W - 1){1'b0}}};
      flags_d.u = 1'b1;
    end else begin
      res_d = {sign2_q, exp2_q, man2_q};
    end
    flags_d.n = res_d[W-1];
    flags_d.z = en2_q && (res_d[W-2:0] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
    end else if (adv_i) begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign res_o   = res_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/vector_fp_mul_pipe.sv
// Vector FP multiplier: LANES parallel 3-stage lanes sharing one valid chain
// and one global advance, with valid/ready handshaking on both sides.
module vector_fp_mul_pipe
  import vfp_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  parameter  int LANES = 8,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            lane_en,
  input  logic [LANES-1:0][WIDTH-1:0] operand1,
  input  logic [LANES-1:0][WIDTH-1:0] operand2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0][WIDTH-1:0] out,
  output logic [LANES-1:0]            V,
  output logic [LANES-1:0]            U,
  output logic [LANES-1:0]            N,
  output logic [LANES-1:0]            Z
);

  logic [2:0] vld_d, vld_q;
  logic       adv;

  // The whole pipe moves together; it only freezes when a finished vector
  // is waiting on the consumer.
  assign adv       = !vld_q[2] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[2];
  assign vld_d     = {vld_q[1:0], in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vfp_flags_t lane_flags;

    vfp_mul_lane #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .en_i   (lane_en[g]),
      .a_i    (operand1[g]),
      .b_i    (operand2[g]),
      .res_o  (out[g]),
      .flags_o(lane_flags)
    );

    assign V[g] = lane_flags.v;
    assign U[g] = lane_flags.u;
    assign N[g] = lane_flags.n;
    assign Z[g] = lane_flags.z;
  end

endmodule

// File: tb/tb_vector_fp_mul_pipe.sv
// Scoreboard bench for vector_fp_mul_pipe (default half-precision, 8 lanes)
// plus a single-lane single-precision instance for the wide build.
module tb_vector_fp_mul_pipe;

  localparam int LANES = 8;
  localparam int W     = 16;

  typedef logic [LANES-1:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t             res;
    logic [LANES-1:0] v;
    logic [LANES-1:0] u;
    logic [LANES-1:0] n;
    logic [LANES-1:0] z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0] lane_en, V, U, N, Z;
  vec_t             operand1, operand2, out;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [0:0]  w_en, w_v, w_u, w_n, w_z;
  logic [31:0] w_a, w_b, w_out;

  exp_t sb_q[$];
  exp_t last_act;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vector_fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .LANES(LANES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .lane_en  (lane_en),
    .operand1 (operand1),
    .operand2 (operand2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .V        (V),
    .U        (U),
    .N        (N),
    .Z        (Z)
  );

  vector_fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .LANES(1)) dut_wide (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .lane_en  (w_en),
    .operand1 (w_a),
    .operand2 (w_b),
    .out_valid(w_out_valid),
    .out_ready(w_out_ready),
    .out      (w_out),
    .V        (w_v),
    .U        (w_u),
    .N        (w_n),
    .Z        (w_z)
  );

  // Reference lane: returns {V,U,N,Z,result} for half precision.
  function automatic logic [19:0] lane_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic en);
    logic [15:0] r;
    logic        s, fv, fu;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    int          ea, eb, e;
    int unsigned ma, mb, p;
    if (!en) return '0;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = int'(a[9:0]);
    mb = int'(b[9:0]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 31) && (ma == 0);
    b_inf  = (eb == 31) && (mb == 0);
    a_nan  = (ea == 31) && (ma != 0);
    b_nan  = (eb == 31) && (mb != 0);
    fv = 1'b0;
    fu = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r  = 16'h7E00;
      fv = 1'b1;
    end else if (a_inf || b_inf) begin
      r = {s, 15'h7C00};
    end else if (a_zero || b_zero) begin
      r = {s, 15'h0000};
    end else begin
      p = (1024 + ma) * (1024 + mb);
      e = ea + eb - 15;
      if (p >= 32'h0020_0000) begin
        p = p >> 1;
        e = e + 1;
      end
      if (e >= 31) begin
        r  = {s, 15'h7C00};
        fv = 1'b1;
      end else if (e <= 0) begin
        r  = {s, 15'h0000};
        fu = 1'b1;
      end else begin
        r = {s, e[4:0], p[19:10]};
      end
    end
    return {fv, fu, r[15], (r[14:0] == 15'h0), r};
  endfunction

  function automatic exp_t model_vec(input vec_t a, input vec_t b, input logic [LANES-1:0] en);
    exp_t        x;
    logic [19:0] l;
    x = '0;
    for (int i = 0; i < LANES; i++) begin
      l        = lane_model(a[i], b[i], en[i]);
      x.res[i] = l[15:0];
      x.v[i]   = l[19];
      x.u[i]   = l[18];
      x.n[i]   = l[17];
      x.z[i]   = l[16];
    end
    return x;
  endfunction

  function automatic vec_t fill(input logic [15:0] x);
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i] = x;
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom());
    case ($urandom_range(0, 9))
      0:       r = {r[15], 15'h0000};
      1:       r = {r[15], 15'h7C00};
      2:       r = {r[15], 5'h1F, r[9:0] | 10'h001};
      default: ;
    endcase
    return r;
  endfunction

  // One cycle: drive at negedge, settle, then score accepts and results.
  task automatic sb_cycle(input logic iv, input logic ordy, input logic [LANES-1:0] en,
                          input vec_t a, input vec_t b, output logic acc, output logic pop);
    exp_t e, act;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    lane_en   = en;
    operand1  = a;
    operand2  = b;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      act      = {out, V, U, N, Z};
      last_act = act;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %h, no result was expected", act);
      end else begin
        e = sb_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL sb_result: got %h expected %h", act, e);
        end
      end
    end
    if (acc) sb_q.push_back(model_vec(a, b, en));
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    lane_en     = '0;
    operand1    = '0;
    operand2    = '0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    w_en        = '0;
    w_a         = '0;
    w_b         = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
    end
    checks++;
    if ({out, V, U, N, Z} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, need all zero", {out, V, U, N, Z});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits up to 8 idle cycles for the next result; returns cycles waited.
  task automatic wait_result(output int lat);
    logic acc, pop;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      sb_cycle(1'b0, 1'b1, '0, '0, '0, acc, pop);
      if (pop) lat = i;
    end
  endtask

  task automatic test_normal();
    vec_t a, b;
    logic acc, pop;
    int   lat;
    a = fill(16'h3C00);
    b = fill(16'h3C00);
    a[0] = 16'h3E00; b[0] = 16'h4000;
    a[1] = 16'hBE00; b[1] = 16'h4000;
    a[2] = 16'h3E00; b[2] = 16'h3E00;
    sb_cycle(1'b1, 1'b1, '1, a, b, acc, pop);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL normal_accept: accepted=%b, need 1", acc);
    end
    wait_result(lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL normal_latency: %0d cycles, need 3", lat);
    end
    checks++;
    if (last_act.res[0] !== 16'h4200 || {last_act.v[0], last_act.u[0], last_act.n[0], last_act.z[0]} !== 4'b0000) begin
      failures++;
      $display("FAIL normal_lane0: got %h flags %b%b%b%b, need 4200 flags 0000", last_act.res[0],
               last_act.v[0], last_act.u[0], last_act.n[0], last_act.z[0]);
    end
    checks++;
    if (last_act.res[1] !== 16'hC200 || last_act.n[1] !== 1'b1) begin
      failures++;
      $display("FAIL normal_lane1: got %h N=%b, need C200 N=1", last_act.res[1], last_act.n[1]);
    end
    checks++;
    if (last_act.res[2] !== 16'h4080) begin
      failures++;
      $display("FAIL normal_lane2_shift: got %h, need 4080", last_act.res[2]);
    end
  endtask

  task automatic test_special();
    vec_t a, b;
    logic acc, pop;
    int   lat;
    a = fill(16'h3C00);
    b = fill(16'h3C00);
    a[0] = 16'h7BFF; b[0] = 16'h4000;
    a[1] = 16'h0400; b[1] = 16'h3800;
    a[2] = 16'h7C00; b[2] = 16'h0000;
    a[3] = 16'h0000; b[3] = 16'hBC00;
    sb_cycle(1'b1, 1'b1, '1, a, b, acc, pop);
    wait_result(lat);
    checks++;
    if (last_act.res[0] !== 16'h7C00 || last_act.v[0] !== 1'b1 || last_act.u[0] !== 1'b0) begin
      failures++;
      $display("FAIL special_overflow: got %h V=%b U=%b, need 7C00 V=1 U=0", last_act.res[0],
               last_act.v[0], last_act.u[0]);
    end
    checks++;
    if (last_act.res[1] !== 16'h0000 || {last_act.v[1], last_act.u[1], last_act.z[1]} !== 3'b011) begin
      failures++;
      $display("FAIL special_underflow: got %h V/U/Z=%b%b%b, need 0000 011", last_act.res[1],
               last_act.v[1], last_act.u[1], last_act.z[1]);
    end
    checks++;
    if (last_act.res[2] !== 16'h7E00 || last_act.v[2] !== 1'b1 || last_act.n[2] !== 1'b0) begin
      failures++;
      $display("FAIL special_inf_x_zero: got %h V=%b N=%b, need 7E00 V=1 N=0", last_act.res[2],
               last_act.v[2], last_act.n[2]);
    end
    checks++;
    if (last_act.res[3] !== 16'h8000 || {last_act.v[3], last_act.u[3], last_act.n[3], last_act.z[3]} !== 4'b0011) begin
      failures++;
      $display("FAIL special_signed_zero: got %h VUNZ=%b%b%b%b, need 8000 0011", last_act.res[3],
               last_act.v[3], last_act.u[3], last_act.n[3], last_act.z[3]);
    end
  endtask

  task automatic test_mask();
    logic        acc, pop;
    int          lat;
    logic [15:0] want;
    sb_cycle(1'b1, 1'b1, 8'b1010_1010, fill(16'h3C00), fill(16'h4000), acc, pop);
    wait_result(lat);
    for (int i = 0; i < LANES; i++) begin
      want = (i % 2 == 1) ? 16'h4000 : 16'h0000;
      checks++;
      if (last_act.res[i] !== want ||
          {last_act.v[i], last_act.u[i], last_act.n[i], last_act.z[i]} !== 4'b0000) begin
        failures++;
        $display("FAIL mask_lane%0d: got %h flags %b%b%b%b, need %h flags 0000", i, last_act.res[i],
                 last_act.v[i], last_act.u[i], last_act.n[i], last_act.z[i], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t a;
    exp_t held;
    logic have_held, acc, pop;
    int   k, pops;
    k         = 0;
    pops      = 0;
    have_held = 1'b0;
    held      = '0;
    for (int c = 0; c < 7; c++) begin
      a    = fill(16'h3C00);
      a[0] = 16'h3C00 + 16'(k * 64);
      sb_cycle(1'b1, 1'b0, '1, a, fill(16'h4000), acc, pop);
      if (acc) k++;
      if (out_valid) begin
        if (!have_held) begin
          held      = {out, V, U, N, Z};
          have_held = 1'b1;
        end else begin
          checks++;
          if ({out, V, U, N, Z} !== held) begin
            failures++;
            $display("FAIL stall_stable: got %h, held value was %h", {out, V, U, N, Z}, held);
          end
        end
      end
    end
    checks++;
    if (k != 3 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_accepts: accepted %0d in_ready=%b, need 3 and 0", k, in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      a    = fill(16'h3C00);
      a[0] = 16'h3C00 + 16'(k * 64);
      sb_cycle(k < 5, 1'b1, '1, a, fill(16'h4000), acc, pop);
      if (acc) k++;
      if (pop) pops++;
    end
    checks++;
    if (pops != 5 || k != 5) begin
      failures++;
      $display("FAIL drain_rate: %0d results and %0d accepts in 5 cycles, need 5 and 5", pops, k);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, pop;
    int   pops;
    sb_cycle(1'b1, 1'b0, '1, fill(16'h3E00), fill(16'h4000), acc, pop);
    sb_cycle(1'b1, 1'b0, '1, fill(16'h4000), fill(16'h4000), acc, pop);
    sb_cycle(1'b0, 1'b0, '0, '0, '0, acc, pop);
    sb_cycle(1'b0, 1'b0, '0, '0, '0, acc, pop);
    checks++;
    if (out_valid !== 1'b1 || out[0] !== 16'h4200) begin
      failures++;
      $display("FAIL midflight_setup: out_valid=%b out0=%h, need 1 and 4200", out_valid, out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out, V, U, N, Z} !== '0) begin
      failures++;
      $display("FAIL midflight_async_clear: out_valid=%b data=%h, need 0", out_valid, {out, V, U, N, Z});
    end
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_cycle(1'b1, 1'b1, '1, fill(16'h3C00), fill(16'h3C00), acc, pop);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_accept: accepted=%b, need 1", acc);
    end
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      sb_cycle(1'b0, 1'b1, '0, '0, '0, acc, pop);
      if (pop) pops++;
    end
    checks++;
    if (pops != 1) begin
      failures++;
      $display("FAIL reset_leftovers: %0d results after release, need 1", pops);
    end
  endtask

  task automatic test_random();
    vec_t a, b;
    logic acc, pop;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < LANES; i++) begin
        a[i] = rand_op();
        b[i] = rand_op();
      end
      sb_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
               LANES'($urandom()), a, b, acc, pop);
    end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) sb_cycle(1'b0, 1'b1, '0, '0, '0, acc, pop);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: %0d results still outstanding, need 0", sb_q.size());
    end
  endtask

  task automatic wide_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                         input logic want_v, input logic want_u);
    logic got;
    @(negedge clk);
    w_in_valid  = 1'b1;
    w_out_ready = 1'b1;
    w_en        = 1'b1;
    w_a         = a;
    w_b         = b;
    @(negedge clk);
    w_in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (w_out_valid) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || w_out !== want || w_v[0] !== want_v || w_u[0] !== want_u) begin
      failures++;
      $display("FAIL wide_%h_x_%h: valid=%b got %h V=%b U=%b, need %h V=%b U=%b", a, b, got,
               w_out, w_v[0], w_u[0], want, want_v, want_u);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_mask();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    wide_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    wide_op(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0);
    wide_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
